mmio_gpio_port: RTL

- Memory-mapped GPIO peripheral on the datapath's shared 64-bit tri-state data bus; consumes ALU-computed addresses and store data, and produces load data.
- Decodes a 64-byte window at BASE_ADDR.
- Holds direction/output registers and drives bidirectional pins.
- Synchronises and debounces pin inputs, and latches rising/falling edge events into a write-1-to-clear status register with a level interrupt output.

---
 rtl/gpio_pkg.sv | 22 ++
 rtl/mmio_gpio_port_if.sv | 12 +
 rtl/gpio_debounce.sv | 52 +++++
 rtl/mmio_gpio_port.sv | 115 +++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
`default_nettype none
// gpio_pkg: GPIO register offsets and default window base, shared with the datapath address map.
// Rev 1.0
package gpio_pkg;

    localparam logic [2:0]  GPIO_DIR        = 3'd0;
    localparam logic [2:0]  GPIO_OUT        = 3'd1;
    localparam logic [2:0]  GPIO_IN         = 3'd2;
    localparam logic [2:0]  GPIO_RISE_EN    = 3'd3;
    localparam logic [2:0]  GPIO_FALL_EN    = 3'd4;
    localparam logic [2:0]  GPIO_IRQ_STATUS = 3'd5;
    localparam logic [2:0]  GPIO_OUT_TOGGLE = 3'd6;

    localparam logic [63:0] GPIO_BASE_ADDR  = 64'h0000_0000_0000_1000;

    // The window is 64 bytes, so only address bits above bit 5 take part in the match.
    function automatic logic gpio_hit(input logic [63:0] addr, input logic [63:0] base);
        return addr[63:6] == base[63:6];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_gpio_port_if.sv
`default_nettype none
// mmio_gpio_port_if: address and strobes of the load/store path into the GPIO window.
// Rev 1.0
interface mmio_gpio_port_if;
    logic [63:0] address;
    logic        read;
    logic        write;

    modport master (output address, read, write);
    modport slave  (input  address, read, write);
endinterface
`default_nettype wire

// File: rtl/gpio_debounce.sv
`default_nettype none
// gpio_debounce: two-flop pin synchroniser plus prescaled two-sample debounce filter.
// Rev 1.0
module gpio_debounce #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic [WIDTH-1:0] pins_i,
    output logic      [WIDTH-1:0] stable_o,
    output logic      [WIDTH-1:0] stable_next_o
);

    localparam int               CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] sample_q, sample_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;

    // A level is accepted only after two consecutive tick samples agree.
    always_comb begin
        tick     = (cnt_q == CNT_MAX);
        cnt_d    = tick ? '0 : cnt_q + CNT_W'(1);
        sample_d = tick ? sync2_q : sample_q;
        stable_d = (tick && (sync2_q == sample_q)) ? sync2_q : stable_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cnt_q    <= '0;
            sample_q <= '0;
            stable_q <= '0;
        end else begin
            sync1_q  <= pins_i;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o      = stable_q;
    assign stable_next_o = stable_d;

endmodule
`default_nettype wire

// File: rtl/mmio_gpio_port.sv
`default_nettype none
// mmio_gpio_port: memory-mapped GPIO with debounced inputs and edge-event interrupt.
// Rev 1.0
module mmio_gpio_port
    import gpio_pkg::*;
#(
    parameter int          WIDTH           = 16,
    parameter logic [63:0] BASE_ADDR       = GPIO_BASE_ADDR,
    parameter int          DEBOUNCE_CYCLES = 4
) (
    input  wire logic             clock,
    input  wire logic             reset,
    mmio_gpio_port_if.slave       bus,
    inout  wire logic [63:0]      data,
    inout  wire logic [WIDTH-1:0] pins,
    output logic                  irq
);

    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] status_q, status_d;
    logic             irq_q;

    logic             hit, wr_en, rd_en;
    logic [2:0]       offset;
    logic [WIDTH-1:0] wdata, status_clr;
    logic [WIDTH-1:0] stable, stable_next, rise, fall, event_set;
    logic [63:0]      rdata;
    logic             unused_bits;

    assign hit         = gpio_hit(bus.address, BASE_ADDR);
    assign offset      = bus.address[5:3];
    assign wr_en       = bus.write & hit;
    assign rd_en       = bus.read & hit & ~bus.write;
    assign wdata       = data[WIDTH-1:0];
    assign unused_bits = ^{bus.address[2:0], data};

    gpio_debounce #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock         (clock),
        .reset         (reset),
        .pins_i        (pins),
        .stable_o      (stable),
        .stable_next_o (stable_next)
    );

    always_comb begin
        dir_d      = dir_q;
        out_d      = out_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        status_clr = '0;
        if (wr_en) begin
            case (offset)
                GPIO_DIR:        dir_d      = wdata;
                GPIO_OUT:        out_d      = wdata;
                GPIO_RISE_EN:    rise_en_d  = wdata;
                GPIO_FALL_EN:    fall_en_d  = wdata;
                GPIO_IRQ_STATUS: status_clr = wdata;
                GPIO_OUT_TOGGLE: out_d      = out_q ^ wdata;
                default:         ;
            endcase
        end
        rise      = stable_next & ~stable;
        fall      = ~stable_next & stable;
        event_set = (rise & rise_en_q) | (fall & fall_en_q);
        // A new event outranks a same-cycle write-1-to-clear.
        status_d  = (status_q & ~status_clr) | event_set;
    end

    always_comb begin
        rdata = '0;
        case (offset)
            GPIO_DIR:        rdata[WIDTH-1:0] = dir_q;
            GPIO_OUT:        rdata[WIDTH-1:0] = out_q;
            GPIO_IN:         rdata[WIDTH-1:0] = stable;
            GPIO_RISE_EN:    rdata[WIDTH-1:0] = rise_en_q;
            GPIO_FALL_EN:    rdata[WIDTH-1:0] = fall_en_q;
            GPIO_IRQ_STATUS: rdata[WIDTH-1:0] = status_q;
            default:         ;
        endcase
    end

    assign data = rd_en ? rdata : 'z;

    always_ff @(posedge clock) begin
        if (reset) begin
            dir_q     <= '0;
            out_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            irq_q     <= 1'b0;
        end else begin
            dir_q     <= dir_d;
            out_q     <= out_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            irq_q     <= |(status_q & (rise_en_q | fall_en_q));
        end
    end

    assign irq = irq_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pins
        assign pins[i] = dir_q[i] ? out_q[i] : 1'bz;
    end

endmodule
`default_nettype wire
